// File: rtl/muldiv_sequencer.sv
// Iterative HI/LO unit: shift-add multiply and restoring divide,
// one result bit per cycle, plus MTHI/MTLO and pipeline stall.
//
// Ports:
//   clk, rst        clock, async active-low reset
//   start, funct    EX-stage instruction valid and ALU funct code
//   op_a, op_b      rs / rt operands
//   flush           cancel in-flight op (no HI/LO update)
//   stall           hold IF..EX (combinational)
//   done            one-cycle pulse after a mul/div write
//   hi, lo          architectural HI/LO registers
module muldiv_sequencer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [5:0]            funct,
  input  logic [DATA_WIDTH-1:0] op_a,
  input  logic [DATA_WIDTH-1:0] op_b,
  input  logic                  flush,
  output logic                  stall,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);

  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } state_t;

  state_t          state;
  logic            is_div;
  logic            sign_a;
  logic            sign_b;
  logic            div0;
  logic [CW-1:0]   count;
  logic [W-1:0]    opnd;
  logic [W-1:0]    raw_a;
  logic [2*W-1:0]  acc;

  logic            is_mul;
  logic            is_dv;
  logic            is_sgn;
  logic            is_mthi;
  logic            is_mtlo;
  logic            is_md;
  logic            neg_a;
  logic            neg_b;
  logic [W-1:0]    abs_a;
  logic [W-1:0]    abs_b;

  always_comb begin
    is_mul  = 1'b0;
    is_dv   = 1'b0;
    is_sgn  = 1'b0;
    is_mthi = 1'b0;
    is_mtlo = 1'b0;
    unique case (1'b1)
      (funct == F_MULT): begin
        is_mul = 1'b1;
        is_sgn = 1'b1;
      end
      (funct == F_MULTU): is_mul = 1'b1;
      (funct == F_DIV): begin
        is_dv  = 1'b1;
        is_sgn = 1'b1;
      end
      (funct == F_DIVU): is_dv   = 1'b1;
      (funct == F_MTHI): is_mthi = 1'b1;
      (funct == F_MTLO): is_mtlo = 1'b1;
      default: ;
    endcase
  end

  assign is_md = is_mul | is_dv;
  assign neg_a = is_sgn & op_a[W-1];
  assign neg_b = is_sgn & op_b[W-1];
  assign abs_a = neg_a ? -op_a : op_a;
  assign abs_b = neg_b ? -op_b : op_b;

  assign stall = (state != S_IDLE)
               | (start & is_md & ~flush);

  // Multiply step: acc = {partial_hi, multiplier}.
  // The add keeps its carry, which becomes the
  // top bit after the right shift.
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_nxt;

  assign mul_sum = {1'b0, acc[2*W-1:W]}
                 + (acc[0] ? {1'b0, opnd} : '0);
  assign mul_nxt = {mul_sum, acc[W-1:1]};

  // Divide step: acc = {remainder, quotient}.
  // The shifted remainder needs one extra bit
  // for the compare against a full-width divisor.
  logic [W:0]     rem_sh;
  logic           rem_ge;
  logic [W-1:0]   rem_sub;
  logic [2*W-1:0] div_nxt;

  assign rem_sh  = {acc[2*W-1:W], acc[W-1]};
  assign rem_ge  = rem_sh >= {1'b0, opnd};
  assign rem_sub = rem_sh[W-1:0] - opnd;
  assign div_nxt = rem_ge
    ? {rem_sub, acc[W-2:0], 1'b1}
    : {rem_sh[W-1:0], acc[W-2:0], 1'b0};

  logic [W-1:0] res_hi;
  logic [W-1:0] res_lo;
  logic         res_neg;

  assign res_neg = sign_a ^ sign_b;

  always_comb begin
    res_hi = acc[2*W-1:W];
    res_lo = acc[W-1:0];
    if (div0) begin
      res_hi = raw_a;
      res_lo = '1;
    end else if (is_div) begin
      res_lo = res_neg ? -acc[W-1:0] : acc[W-1:0];
      res_hi = sign_a ? -acc[2*W-1:W]
                      : acc[2*W-1:W];
    end else if (res_neg) begin
      {res_hi, res_lo} = -acc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      acc    <= '0;
      opnd   <= '0;
      raw_a  <= '0;
      count  <= '0;
      is_div <= 1'b0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      div0   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= S_IDLE;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (start & is_md) begin
              is_div <= is_dv;
              sign_a <= neg_a;
              sign_b <= neg_b;
              raw_a  <= op_a;
              count  <= '0;
              div0   <= is_dv & (op_b == '0);
              acc    <= {{W{1'b0}},
                         is_dv ? abs_a : abs_b};
              opnd   <= is_dv ? abs_b : abs_a;
              if (is_dv & (op_b == '0))
                state <= S_FIX;
              else
                state <= S_RUN;
            end else if (start & is_mthi) begin
              hi <= op_a;
            end else if (start & is_mtlo) begin
              lo <= op_a;
            end
          end
          S_RUN: begin
            acc   <= is_div ? div_nxt : mul_nxt;
            count <= count + CW'(1);
            if (count == CW'(W - 1))
              state <= S_FIX;
          end
          S_FIX: begin
            hi    <= res_hi;
            lo    <= res_lo;
            done  <= 1'b1;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
